// File: rtl/commit_trace_feeder.sv
// Buffers retired PC/insn pairs (two lanes) and feeds them one at a time to the
// lockstep checker, collecting match/miss/insn-error statistics.
module commit_trace_feeder #(
    parameter int          DEPTH        = 16,
    parameter logic [63:0] IDLE_PC      = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter bit          STOP_ON_MISS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [1:0]               retire_vld,
    input  logic [63:0]              retire_pc0,
    input  logic [31:0]              retire_insn0,
    input  logic [63:0]              retire_pc1,
    input  logic [31:0]              retire_insn1,
    output logic                     retire_stall,
    output logic [63:0]              chk_pc,
    input  logic [63:0]              ref_pc,
    input  logic [31:0]              ref_insn,
    input  logic                     ref_miss,
    output logic                     halted,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [31:0]              match_cnt,
    output logic [31:0]              miss_cnt,
    output logic [31:0]              insn_err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, PRESENT, CHECK, HALTED} state_t;

    logic [63:0]   pc_mem   [DEPTH];
    logic [31:0]   insn_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, free_cnt, push_cnt, lvl_after_pop;
    state_t        state, state_nxt;
    logic [63:0]   chk_pc_nxt, next_head_pc;
    logic          acc0, acc1, drop;
    logic          pop, halt_set, cnt_match, cnt_miss, cnt_err;

    // The checker reports the compare outcome through ref_miss; the reference PC itself is not needed.
    logic unused_ref_pc;
    assign unused_ref_pc = ^ref_pc;

    assign fifo_level   = level;
    assign free_cnt     = LW'(DEPTH) - level;
    assign retire_stall = free_cnt < LW'(2);

    // Lane0 takes the first free slot, so lane1 is the one dropped when only one remains.
    assign acc0     = retire_vld[0] && (free_cnt != '0);
    assign acc1     = retire_vld[1] && (free_cnt > LW'(acc0));
    assign drop     = (retire_vld[0] && !acc0) || (retire_vld[1] && !acc1);
    assign push_cnt = LW'(acc0) + LW'(acc1);

    assign lvl_after_pop = level + push_cnt - LW'(1);
    // If the popped entry was the last stored one, the next head is being written this cycle.
    assign next_head_pc  = (level != LW'(1)) ? pc_mem[rd_ptr + AW'(1)] :
                           (acc0 ? retire_pc0 : retire_pc1);

    always_comb begin
        state_nxt  = state;
        chk_pc_nxt = IDLE_PC;
        pop        = 1'b0;
        halt_set   = 1'b0;
        cnt_match  = 1'b0;
        cnt_miss   = 1'b0;
        cnt_err    = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0 && enable && !halted) begin
                    state_nxt  = PRESENT;
                    chk_pc_nxt = pc_mem[rd_ptr];
                end
            end
            PRESENT: state_nxt = CHECK;
            CHECK: begin
                if (!ref_miss) begin
                    cnt_match = 1'b1;
                    cnt_err   = (ref_insn != insn_mem[rd_ptr]);
                    pop       = 1'b1;
                end else begin
                    cnt_miss = 1'b1;
                    if (STOP_ON_MISS) halt_set = 1'b1;
                    else              pop      = 1'b1;
                end
                if (halt_set) begin
                    state_nxt = HALTED;
                end else if (lvl_after_pop != '0 && enable) begin
                    state_nxt  = PRESENT;
                    chk_pc_nxt = next_head_pc;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            chk_pc       <= IDLE_PC;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            halted       <= 1'b0;
            overflow     <= 1'b0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            insn_err_cnt <= '0;
        end else begin
            state  <= state_nxt;
            chk_pc <= chk_pc_nxt;
            wr_ptr <= wr_ptr + AW'(push_cnt);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + push_cnt - LW'(pop);
            if (halt_set) halted   <= 1'b1;
            if (drop)     overflow <= 1'b1;
            if (cnt_match && match_cnt != '1)    match_cnt    <= match_cnt + 32'd1;
            if (cnt_miss && miss_cnt != '1)      miss_cnt     <= miss_cnt + 32'd1;
            if (cnt_err && insn_err_cnt != '1)   insn_err_cnt <= insn_err_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) begin
            pc_mem[wr_ptr]   <= retire_pc0;
            insn_mem[wr_ptr] <= retire_insn0;
        end
        if (acc1) begin
            pc_mem[wr_ptr + AW'(acc0)]   <= retire_pc1;
            insn_mem[wr_ptr + AW'(acc0)] <= retire_insn1;
        end
    end

endmodule

// File: tb/tb_commit_trace_feeder.sv
// Directed bench: u_a is DEPTH=16 halting on miss, u_b is DEPTH=4 continuing on miss;
// both see the same stimulus.
module tb_commit_trace_feeder;

    localparam logic [63:0] IDLE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, enable, ref_miss;
    logic [1:0]  retire_vld;
    logic [63:0] retire_pc0, retire_pc1, ref_pc;
    logic [31:0] retire_insn0, retire_insn1, ref_insn;

    logic        stall_a, halted_a, ovf_a, stall_b, halted_b, ovf_b;
    logic [63:0] chk_a, chk_b;
    logic [4:0]  lvl_a;
    logic [2:0]  lvl_b;
    logic [31:0] match_a, miss_a, err_a, match_b, miss_b, err_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    commit_trace_feeder #(.DEPTH(16), .STOP_ON_MISS(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .retire_vld(retire_vld),
        .retire_pc0(retire_pc0), .retire_insn0(retire_insn0),
        .retire_pc1(retire_pc1), .retire_insn1(retire_insn1),
        .retire_stall(stall_a), .chk_pc(chk_a), .ref_pc(ref_pc), .ref_insn(ref_insn),
        .ref_miss(ref_miss), .halted(halted_a), .overflow(ovf_a), .fifo_level(lvl_a),
        .match_cnt(match_a), .miss_cnt(miss_a), .insn_err_cnt(err_a));

    commit_trace_feeder #(.DEPTH(4), .STOP_ON_MISS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .retire_vld(retire_vld),
        .retire_pc0(retire_pc0), .retire_insn0(retire_insn0),
        .retire_pc1(retire_pc1), .retire_insn1(retire_insn1),
        .retire_stall(stall_b), .chk_pc(chk_b), .ref_pc(ref_pc), .ref_insn(ref_insn),
        .ref_miss(ref_miss), .halted(halted_b), .overflow(ovf_b), .fifo_level(lvl_b),
        .match_cnt(match_b), .miss_cnt(miss_b), .insn_err_cnt(err_b));

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [1:0]  vld;
        logic [63:0] pc0;
        logic [31:0] insn0;
        logic [63:0] pc1;
        logic [31:0] insn1;
        logic        miss;
        logic [31:0] rinsn;
        logic [63:0] e_chk;
        int          e_lvl;
        int          e_match;
        int          e_err;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [63:0] pc0, input logic [31:0] i0,
                         input logic [63:0] pc1, input logic [31:0] i1);
        retire_vld   = vld;
        retire_pc0   = pc0;
        retire_insn0 = i0;
        retire_pc1   = pc1;
        retire_insn1 = i1;
    endtask

    function automatic vec_t mk(logic r, logic e, logic [1:0] v, logic [63:0] p0, logic [31:0] i0,
                                logic [63:0] p1, logic [31:0] i1, logic m, logic [31:0] ri,
                                logic [63:0] ec, int el, int em, int ee);
        vec_t t;
        t.rst_n = r; t.en = e; t.vld = v; t.pc0 = p0; t.insn0 = i0; t.pc1 = p1; t.insn1 = i1;
        t.miss = m; t.rinsn = ri; t.e_chk = ec; t.e_lvl = el; t.e_match = em; t.e_err = ee;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_pc [4];
        int n;

        // Dual push + two matches, then a lane1-only push whose insn mismatches.
        vecs[0]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, IDLE, 0, 0, 0);
        vecs[1]  = mk(1, 1, 2'b11, 64'h8000_0000, 32'h00a00093, 64'h8000_0004, 32'h00b00113,
                      0, 32'h00a00093, IDLE, 2, 0, 0);
        vecs[2]  = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00a00093, 64'h8000_0000, 2, 0, 0);
        vecs[3]  = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00a00093, IDLE, 2, 0, 0);
        vecs[4]  = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00a00093, 64'h8000_0004, 1, 1, 0);
        vecs[5]  = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00b00113, IDLE, 1, 1, 0);
        vecs[6]  = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00b00113, IDLE, 0, 2, 0);
        vecs[7]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00000013, IDLE, 0, 0, 0);
        vecs[8]  = mk(1, 1, 2'b10, 0, 0, 64'h8000_0008, 32'h00100093, 0, 32'h00000013, IDLE, 1, 0, 0);
        vecs[9]  = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00000013, 64'h8000_0008, 1, 0, 0);
        vecs[10] = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00000013, IDLE, 1, 0, 0);
        vecs[11] = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00000013, IDLE, 0, 1, 1);
        vecs[12] = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 32'h00000013, IDLE, 0, 1, 1);

        ref_pc = '0;
        for (int i = 0; i < 13; i++) begin
            rst_n = vecs[i].rst_n; enable = vecs[i].en; ref_miss = vecs[i].miss;
            ref_insn = vecs[i].rinsn;
            drive(vecs[i].vld, vecs[i].pc0, vecs[i].insn0, vecs[i].pc1, vecs[i].insn1);
            tick();
            check($sformatf("v%0d chk_pc", i), chk_a, vecs[i].e_chk);
            check($sformatf("v%0d level", i), 64'(lvl_a), 64'(vecs[i].e_lvl));
            check($sformatf("v%0d match", i), 64'(match_a), 64'(vecs[i].e_match));
            check($sformatf("v%0d insn_err", i), 64'(err_a), 64'(vecs[i].e_err));
            check($sformatf("v%0d halted", i), 64'(halted_a), 64'(0));
            check($sformatf("v%0d stall", i), 64'(stall_a), 64'(0));
        end
        check("reset miss_cnt", 64'(miss_a), 64'(0));
        check("reset overflow", 64'(ovf_a), 64'(0));

        // Halt on first miss (u_a).
        rst_n = 0; ref_miss = 0; drive(2'b00, 0, 0, 0, 0); tick();
        rst_n = 1; enable = 1; ref_insn = 32'h13;
        drive(2'b01, 64'h100, 32'h13, 0, 0); tick();
        drive(2'b00, 0, 0, 0, 0); tick();
        check("halt present", chk_a, 64'h100);
        tick();
        ref_miss = 1; tick();
        check("halt halted", 64'(halted_a), 64'(1));
        check("halt miss_cnt", 64'(miss_a), 64'(1));
        check("halt level", 64'(lvl_a), 64'(1));
        check("halt chk_pc", chk_a, IDLE);
        ref_miss = 0;
        drive(2'b11, 64'h104, 32'h13, 64'h108, 32'h13); tick();
        drive(2'b00, 0, 0, 0, 0); tick(); tick(); tick();
        check("halted chk_pc", chk_a, IDLE);
        check("halted push level", 64'(lvl_a), 64'(3));
        check("halted match_cnt", 64'(match_a), 64'(0));
        check("halted sticky", 64'(halted_a), 64'(1));

        // Miss on first of three without halting (u_b).
        rst_n = 0; tick();
        rst_n = 1; enable = 1; ref_miss = 0; ref_insn = 32'h13;
        drive(2'b11, 64'h200, 32'h13, 64'h204, 32'h13); tick();
        drive(2'b01, 64'h208, 32'h13, 0, 0); tick();
        check("nohalt present0", chk_b, 64'h200);
        check("nohalt level3", 64'(lvl_b), 64'(3));
        drive(2'b00, 0, 0, 0, 0); tick();
        ref_miss = 1; tick();
        check("nohalt present1", chk_b, 64'h204);
        check("nohalt miss_cnt", 64'(miss_b), 64'(1));
        check("nohalt level2", 64'(lvl_b), 64'(2));
        ref_miss = 0; tick(); tick();
        check("nohalt present2", chk_b, 64'h208);
        tick(); tick();
        check("nohalt match_cnt", 64'(match_b), 64'(2));
        check("nohalt drained", 64'(lvl_b), 64'(0));
        check("nohalt halted", 64'(halted_b), 64'(0));
        check("nohalt chk_pc", chk_b, IDLE);

        // Overflow with enable held low (u_b DEPTH=4), then drain in order.
        rst_n = 0; tick();
        rst_n = 1; enable = 0;
        drive(2'b11, 64'h300, 32'h13, 64'h304, 32'h13); tick();
        check("ovf level2", 64'(lvl_b), 64'(2));
        check("ovf stall@2", 64'(stall_b), 64'(0));
        drive(2'b11, 64'h308, 32'h13, 64'h30C, 32'h13); tick();
        check("ovf level4", 64'(lvl_b), 64'(4));
        check("ovf stall@4", 64'(stall_b), 64'(1));
        check("ovf flag early", 64'(ovf_b), 64'(0));
        drive(2'b01, 64'h310, 32'h13, 0, 0); tick();
        check("ovf flag", 64'(ovf_b), 64'(1));
        check("ovf level held", 64'(lvl_b), 64'(4));
        check("ovf chk idle while disabled", chk_b, IDLE);
        check("ovf big fifo level", 64'(lvl_a), 64'(5));
        check("ovf big fifo flag", 64'(ovf_a), 64'(0));
        drive(2'b00, 0, 0, 0, 0);
        exp_pc[0] = 64'h300; exp_pc[1] = 64'h304; exp_pc[2] = 64'h308; exp_pc[3] = 64'h30C;
        enable = 1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (chk_b === IDLE && n < 8) begin tick(); n++; end
            if (n == 8) check($sformatf("drain%0d timeout", k), 64'(1), 64'(0));
            else        check($sformatf("drain%0d pc", k), chk_b, exp_pc[k]);
            tick();
        end
        n = 0;
        while (lvl_b != 0 && n < 8) begin tick(); n++; end
        check("drain level", 64'(lvl_b), 64'(0));
        check("drain match_cnt", 64'(match_b), 64'(4));
        check("drain overflow sticky", 64'(ovf_b), 64'(1));
        for (int k = 0; k < 6; k++) tick();
        check("drain big level", 64'(lvl_a), 64'(0));
        check("drain big match_cnt", 64'(match_a), 64'(5));

        // Reset in the middle of a check.
        drive(2'b11, 64'h400, 32'h13, 64'h404, 32'h13); tick();
        drive(2'b01, 64'h408, 32'h13, 0, 0); tick();
        drive(2'b00, 0, 0, 0, 0); tick();
        check("midrst pre level", 64'(lvl_b), 64'(3));
        rst_n = 0; tick();
        check("midrst level", 64'(lvl_b), 64'(0));
        check("midrst match_cnt", 64'(match_b), 64'(0));
        check("midrst overflow", 64'(ovf_b), 64'(0));
        check("midrst chk_pc", chk_b, IDLE);
        check("midrst big level", 64'(lvl_a), 64'(0));
        rst_n = 1; tick(); tick();
        check("midrst idle chk_pc", chk_b, IDLE);
        check("midrst idle level", 64'(lvl_b), 64'(0));
        check("midrst idle match", 64'(match_b), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
